// File: rtl/conv_layer_scheduler.sv
// Layer sequencer for a conv accelerator: walks each layer through weight LOAD,
// MAC COMPUTE and pipeline DRAIN, then advances the layer index until the run is done.
module conv_layer_scheduler #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned MAX_LAYERS   = 8,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       cfg_layers,
   input  logic [CNT_W-1:0] cfg_wt_beats,
   input  logic [CNT_W-1:0] cfg_tiles,
   input  logic             ddr_valid,
   input  logic             mac_valid,
   output logic             wt_load_en,
   output logic             mac_en,
   output logic [2:0]       current_state,
   output logic             state_rst,
   output logic [3:0]       layer_idx,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [3:0]    MAX_L      = 4'(MAX_LAYERS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_NEXT    = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         layers_q, layers_d;
   logic [CNT_W-1:0]   wt_beats_q, wt_beats_d;
   logic [CNT_W-1:0]   tiles_q, tiles_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [3:0]         layer_idx_q, layer_idx_d;

   logic wt_load_en_q, mac_en_q, state_rst_q, busy_q, done_q;

   // Zero layers means one; anything beyond the hardware limit is clamped.
   function automatic logic [3:0] eff_layers(input logic [3:0] n);
      if (n == 4'd0) return 4'd1;
      if (n > MAX_L) return MAX_L;
      return n;
   endfunction

   // First state of a layer, skipping phases whose work count is zero.
   function automatic state_e first_state(input logic [CNT_W-1:0] wt,
                                          input logic [CNT_W-1:0] tl);
      if (wt != '0) return S_LOAD;
      if (tl != '0) return S_COMPUTE;
      return S_DRAIN;
   endfunction

   always_comb begin
      state_d     = state_q;
      layers_d    = layers_q;
      wt_beats_d  = wt_beats_q;
      tiles_d     = tiles_q;
      beat_cnt_d  = beat_cnt_q;
      tile_cnt_d  = tile_cnt_q;
      drain_cnt_d = '0;
      layer_idx_d = layer_idx_q;

      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         beat_cnt_d  = '0;
         tile_cnt_d  = '0;
         layer_idx_d = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  layers_d    = eff_layers(cfg_layers);
                  wt_beats_d  = cfg_wt_beats;
                  tiles_d     = cfg_tiles;
                  beat_cnt_d  = '0;
                  tile_cnt_d  = '0;
                  layer_idx_d = 4'd0;
                  state_d     = first_state(cfg_wt_beats, cfg_tiles);
               end
            end
            S_LOAD: begin
               if (ddr_valid) begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
                  if ((beat_cnt_q + CNT_W'(1)) == wt_beats_q)
                     state_d = (tiles_q == '0) ? S_DRAIN : S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (mac_valid) begin
                  tile_cnt_d = tile_cnt_q + CNT_W'(1);
                  if ((tile_cnt_q + CNT_W'(1)) == tiles_q)
                     state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt_q == DRAIN_LAST) state_d = S_NEXT;
               else                           drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
            S_NEXT: begin
               if (layer_idx_q == (layers_q - 4'd1)) begin
                  state_d = S_DONE;
               end else begin
                  layer_idx_d = layer_idx_q + 4'd1;
                  beat_cnt_d  = '0;
                  tile_cnt_d  = '0;
                  state_d     = first_state(wt_beats_q, tiles_q);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with current_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         layers_q     <= 4'd0;
         wt_beats_q   <= '0;
         tiles_q      <= '0;
         beat_cnt_q   <= '0;
         tile_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         layer_idx_q  <= 4'd0;
         wt_load_en_q <= 1'b0;
         mac_en_q     <= 1'b0;
         state_rst_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         layers_q     <= layers_d;
         wt_beats_q   <= wt_beats_d;
         tiles_q      <= tiles_d;
         beat_cnt_q   <= beat_cnt_d;
         tile_cnt_q   <= tile_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         layer_idx_q  <= layer_idx_d;
         wt_load_en_q <= (state_d == S_LOAD);
         mac_en_q     <= (state_d == S_COMPUTE);
         state_rst_q  <= (state_d != state_q);
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
      end
   end

   assign current_state = state_q;
   assign layer_idx     = layer_idx_q;
   assign wt_load_en    = wt_load_en_q;
   assign mac_en        = mac_en_q;
   assign state_rst     = state_rst_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed cycle-by-cycle bench for conv_layer_scheduler: each step drives inputs,
// clocks once and compares every output against hand-computed expectations.
module tb_conv_layer_scheduler;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, start, abort, ddr_valid, mac_valid;
   logic [3:0]       cfg_layers;
   logic [CNT_W-1:0] cfg_wt_beats, cfg_tiles;
   logic             wt_load_en, mac_en, state_rst, busy, done;
   logic [2:0]       current_state;
   logic [3:0]       layer_idx;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       r, s, a, d, m;
      logic [2:0] st;
      logic [3:0] li;
      logic       sr, dn;
   } vec_t;

   vec_t tbl[$];

   conv_layer_scheduler #(.CNT_W(CNT_W), .MAX_LAYERS(8), .DRAIN_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_layers(cfg_layers), .cfg_wt_beats(cfg_wt_beats), .cfg_tiles(cfg_tiles),
      .ddr_valid(ddr_valid), .mac_valid(mac_valid),
      .wt_load_en(wt_load_en), .mac_en(mac_en), .current_state(current_state),
      .state_rst(state_rst), .layer_idx(layer_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, clock, then compare all outputs just after the edge.
   task automatic step(input logic r, s, a, d, m, input logic [2:0] st,
                       input logic [3:0] li, input logic sr, dn, input string name);
      logic [12:0] got, exp;
      rst = r; start = s; abort = a; ddr_valid = d; mac_valid = m;
      @(posedge clk);
      #1;
      got = {current_state, layer_idx, wt_load_en, mac_en, state_rst, busy, done};
      exp = {st, li, (st == 3'd1), (st == 3'd2), sr, (st != 3'd0), dn};
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got state=%0d layer=%0d wt=%b mac=%b srst=%b busy=%b done=%b, expected state=%0d layer=%0d wt=%b mac=%b srst=%b busy=%b done=%b",
                  name, got[12:10], got[9:6], got[5], got[4], got[3], got[2], got[1],
                  exp[12:10], exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1]);
      end
   endtask

   task automatic add(input logic r, s, a, d, m, input logic [2:0] st,
                      input logic [3:0] li, input logic sr, dn);
      vec_t v;
      v.r = r; v.s = s; v.a = a; v.d = d; v.m = m;
      v.st = st; v.li = li; v.sr = sr; v.dn = dn;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 3'd0, 4'd0, 0, 0, "reset");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; ddr_valid = 1'b0; mac_valid = 1'b0;
      cfg_layers = 4'd2; cfg_wt_beats = 16'd3; cfg_tiles = 16'd2;

      // Nominal two-layer run: 3 beats, 2 tiles, 4 drain cycles per layer.
      add(1,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 1,0,1,0);
      add(0,0,0,1,0, 1,0,0,0);
      add(0,0,0,0,0, 1,0,0,0);
      add(0,0,0,1,0, 1,0,0,0);
      add(0,0,0,1,0, 2,0,1,0);
      add(0,0,0,0,1, 2,0,0,0);
      add(0,0,0,0,1, 3,0,1,0);
      add(0,0,0,0,0, 3,0,0,0);
      add(0,0,0,0,0, 3,0,0,0);
      add(0,0,0,0,0, 3,0,0,0);
      add(0,0,0,0,0, 4,0,1,0);
      add(0,0,0,0,0, 1,1,1,0);
      add(0,0,0,1,0, 1,1,0,0);
      add(0,0,0,1,0, 1,1,0,0);
      add(0,0,0,1,0, 2,1,1,0);
      add(0,0,0,0,1, 2,1,0,0);
      add(0,0,0,0,1, 3,1,1,0);
      add(0,0,0,0,0, 3,1,0,0);
      add(0,0,0,0,0, 3,1,0,0);
      add(0,0,0,0,0, 3,1,0,0);
      add(0,0,0,0,0, 4,1,1,0);
      add(0,0,0,0,0, 5,1,1,1);
      add(0,0,0,0,0, 0,1,1,0);
      add(0,0,0,0,0, 0,1,0,0);
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].m,
              tbl[i].st, tbl[i].li, tbl[i].sr, tbl[i].dn, $sformatf("nominal[%0d]", i));

      // Gapped ddr_valid: four beats on every other cycle keep LOAD for 8 cycles.
      do_reset();
      cfg_layers = 4'd1; cfg_wt_beats = 16'd4; cfg_tiles = 16'd1;
      step(0,1,0,0,0, 1,0,1,0, "gap_start");
      for (int k = 1; k <= 8; k++)
         if (k < 8) step(0,0,0,(k % 2 == 0),0, 1,0,0,0, $sformatf("gap_load%0d", k));
         else       step(0,0,0,1,0,            2,0,1,0, "gap_exit");
      step(0,0,0,0,1, 3,0,1,0, "gap_drain0");
      for (int k = 1; k < 4; k++) step(0,0,0,0,0, 3,0,0,0, $sformatf("gap_drain%0d", k));
      step(0,0,0,0,0, 4,0,1,0, "gap_next");
      step(0,0,0,0,0, 5,0,1,1, "gap_done");
      step(0,0,0,0,0, 0,0,1,0, "gap_idle");

      // Both phases skipped: straight to DRAIN.
      cfg_layers = 4'd1; cfg_wt_beats = 16'd0; cfg_tiles = 16'd0;
      step(0,1,0,0,0, 3,0,1,0, "skip_drain0");
      for (int k = 1; k < 4; k++) step(0,0,0,0,0, 3,0,0,0, $sformatf("skip_drain%0d", k));
      step(0,0,0,0,0, 4,0,1,0, "skip_next");
      step(0,0,0,0,0, 5,0,1,1, "skip_done");
      step(0,0,0,0,0, 0,0,1,0, "skip_idle");

      // Abort in the second COMPUTE cycle of layer 1, then restart immediately.
      do_reset();
      cfg_layers = 4'd2; cfg_wt_beats = 16'd1; cfg_tiles = 16'd3;
      step(0,1,0,0,0, 1,0,1,0, "ab_load0");
      step(0,0,0,1,0, 2,0,1,0, "ab_comp0");
      step(0,0,0,0,1, 2,0,0,0, "ab_mac1");
      step(0,0,0,0,1, 2,0,0,0, "ab_mac2");
      step(0,0,0,0,1, 3,0,1,0, "ab_drain0");
      for (int k = 1; k < 4; k++) step(0,0,0,0,0, 3,0,0,0, $sformatf("ab_drain%0d", k));
      step(0,0,0,0,0, 4,0,1,0, "ab_next");
      step(0,0,0,0,0, 1,1,1,0, "ab_load1");
      step(0,0,0,1,0, 2,1,1,0, "ab_comp1");
      step(0,0,0,0,0, 2,1,0,0, "ab_comp1_c2");
      step(0,0,1,0,1, 0,0,1,0, "ab_abort");
      cfg_wt_beats = 16'd2;
      step(0,1,0,0,0, 1,0,1,0, "ab_restart");
      step(0,0,0,1,0, 1,0,0,0, "ab_restart_beat");

      // Reset mid-DRAIN, with start and abort asserted alongside it.
      do_reset();
      cfg_layers = 4'd1; cfg_wt_beats = 16'd0; cfg_tiles = 16'd0;
      step(0,1,0,0,0, 3,0,1,0, "rst_drain0");
      step(0,0,0,0,0, 3,0,0,0, "rst_drain1");
      step(1,1,1,0,0, 0,0,0,0, "rst_mid");
      step(0,0,0,0,0, 0,0,0,0, "rst_exit");
      step(0,0,0,0,0, 0,0,0,0, "rst_idle");

      // Clamped layer count; start, stray handshakes and cfg changes mid-run ignored.
      cfg_layers = 4'd15; cfg_wt_beats = 16'd1; cfg_tiles = 16'd1;
      step(0,1,0,0,0, 1,0,1,0, "clamp_start");
      cfg_layers = 4'd3; cfg_wt_beats = 16'd5; cfg_tiles = 16'd0;
      for (int l = 0; l < 8; l++) begin
         step(0,1,0,0,1, 1,4'(l),0,0, $sformatf("clamp_l%0d_ign", l));
         step(0,0,0,1,0, 2,4'(l),1,0, $sformatf("clamp_l%0d_comp", l));
         step(0,1,0,1,0, 2,4'(l),0,0, $sformatf("clamp_l%0d_ign2", l));
         step(0,0,0,0,1, 3,4'(l),1,0, $sformatf("clamp_l%0d_drain", l));
         for (int k = 1; k < 4; k++)
            step(0,0,0,0,0, 3,4'(l),0,0, $sformatf("clamp_l%0d_drain%0d", l, k));
         step(0,0,0,0,0, 4,4'(l),1,0, $sformatf("clamp_l%0d_next", l));
         if (l < 7) step(0,0,0,0,0, 1,4'(l+1),1,0, $sformatf("clamp_l%0d_adv", l));
         else       step(0,0,0,0,0, 5,4'd7,1,1,   "clamp_done");
      end
      step(0,0,0,0,0, 0,7,1,0, "clamp_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 SHALL have parameters, one per line:
- CNT_W, default 16: width of the beat and tile counters.
- MAX_LAYERS, default 8: largest supported layer count.
- DRAIN_CYCLES, default 4: MAC pipeline flush cycles.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; ports are, one per line:
- clk  in  1: single clock; all logic on its rising edge.
- rst  in  1: synchronous active-high reset.
- start  in  1: begin a run; sampled only in IDLE.
- abort  in  1: synchronous abort of a run.
- cfg_layers  in  4: layers per run; 0 is treated as 1; values above MAX_LAYERS are clamped to MAX_LAYERS.
- cfg_wt_beats  in  CNT_W: DDR weight beats per layer; 0 skips LOAD.
- cfg_tiles  in  CNT_W: MAC result tiles per layer; 0 skips COMPUTE.
- ddr_valid  in  1: one weight beat accepted by weight memory.
- mac_valid  in  1: one MAC output tile completed.
- wt_load_en  out  1: weight memory write enable.
- mac_en  out  1: conv datapath enable.
- current_state  out  3: state code, broadcast to weight memory and conv unit.
- state_rst  out  1: one-cycle pulse on every state entry.
- layer_idx  out  4: index of the current layer, starting at 0.
- busy  out  1: high whenever state is not IDLE.
- done  out  1: one-cycle run-complete pulse.

Function
REQ-003 SHALL encode states as IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, NEXT=4, DONE=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-004 SHALL, in IDLE with start=1, latch cfg_layers, cfg_wt_beats and cfg_tiles, and clear layer_idx and all counters.
- Next state: LOAD, or COMPUTE if cfg_wt_beats=0, or DRAIN if both cfg_wt_beats and cfg_tiles are 0.
REQ-005 SHALL ignore start while busy; configuration inputs are not re-sampled during a run.
REQ-006 SHALL hold wt_load_en=1 throughout LOAD and count ddr_valid beats.
- On the cycle the accepted beat makes count = latched cfg_wt_beats, the next state is COMPUTE, or DRAIN if cfg_tiles=0.
REQ-007 SHALL hold mac_en=1 throughout COMPUTE and count mac_valid pulses.
- On the cycle the pulse makes count = latched cfg_tiles, the next state is DRAIN.
REQ-008 SHALL stay in DRAIN for exactly DRAIN_CYCLES cycles, with mac_en=0, then go to NEXT.
REQ-009 SHALL spend one cycle in NEXT.
- If layer_idx = effective layers-1: next state DONE, layer_idx unchanged.
- Otherwise: layer_idx increments, counters clear, next state LOAD (same skip rules as REQ-004).
REQ-010 SHALL spend one cycle in DONE with done=1, then go to IDLE.
REQ-011 SHALL assert state_rst for exactly the first cycle of each newly entered state.
- This includes IDLE entry by abort, by DONE exit, or from an illegal code.
- It is not asserted on reset exit.
REQ-012 SHALL, when abort=1 in any non-IDLE state, enter IDLE on the next cycle and clear counters and layer_idx.
- done is not asserted.
- abort has priority over every other transition in that cycle.
REQ-013 SHALL ignore ddr_valid outside LOAD and mac_valid outside COMPUTE.
- Counters never exceed their latched targets.
REQ-014 SHALL drive every output from registers; there is no combinational path from any input to any output.
REQ-015 SHALL give counter equality priority over wrap-around: counters are CNT_W wide and never wrap in legal operation.

Reset
REQ-016 SHALL, with rst=1 at a clock edge, set state=IDLE and clear all counters, latched configuration and every output to 0, regardless of the current state.
REQ-017 SHALL give rst priority over abort and start.
REQ-018 SHALL treat rst asserted mid-run identically to power-up: no done pulse and no state_rst pulse.

Verification
REQ-019 Nominal run SHALL be covered:
- Stimulus: cfg_layers=2, cfg_wt_beats=3, cfg_tiles=2, DRAIN_CYCLES=4, start.
- Response: state sequence 1,2,3,4,1,2,3,4,5,0; layer_idx goes 0 then 1; done pulses once; state_rst pulses 10 times.
REQ-020 Gapped handshakes SHALL be covered:
- Stimulus: ddr_valid asserted on every other cycle with cfg_wt_beats=4.
- Response: LOAD lasts 8 cycles; wt_load_en stays high for all 8.
REQ-021 Skip rules SHALL be covered:
- Stimulus: cfg_wt_beats=0, cfg_tiles=0, cfg_layers=1, start.
- Response: state goes IDLE->DRAIN (4 cycles)->NEXT->DONE->IDLE.
REQ-022 Abort SHALL be covered:
- Stimulus: abort on the 2nd COMPUTE cycle of layer 1.
- Response: next cycle state=0, layer_idx=0, state_rst=1, done=0.
- A start in that IDLE cycle begins a new run.
REQ-023 Reset mid-run SHALL be covered:
- Stimulus: rst during DRAIN.
- Response: all outputs 0 on the next cycle; no state_rst or done pulse.
REQ-024 Ignored and clamped inputs SHALL be covered:
- Stimulus: start asserted during LOAD; mac_valid during LOAD; cfg_layers=15.
- Response: no effect on the run; layer_idx reaches 7 and the run completes after 8 layers.
